// File: rtl/game_pkg.sv
// Shared scene constants and screen encodings for the game sequencer and pixel renderer.
// Positions are 32-bit signed pixels; the score is unsigned.
package game_pkg;

  typedef logic signed [31:0] pos_t;

  typedef enum logic [1:0] {
    SCREEN_TITLE     = 2'd0,
    SCREEN_PLAY      = 2'd1,
    SCREEN_GAME_OVER = 2'd2
  } screen_e;

  localparam pos_t SCREEN_WIDTH  = 640;
  localparam pos_t SCREEN_HEIGHT = 480;

  localparam pos_t BIRD_X        = 303;
  localparam pos_t BIRD_WIDTH    = 34;
  localparam pos_t BIRD_HEIGHT   = 24;
  localparam pos_t BIRD_START_Y  = 228;

  localparam pos_t PIPE_WIDTH    = 52;
  localparam pos_t PIPE_GAP      = 100;
  localparam pos_t PIPE_SPACING  = 240;
  localparam pos_t PIPE_SPEED    = 2;
  localparam pos_t PIPE_SPEED_MAX = 4;
  localparam pos_t PIPE_Y_MIN    = 60;
  localparam pos_t PIPE_RESET_Y  = (SCREEN_HEIGHT - PIPE_GAP) / 2;

  localparam pos_t GRAVITY       = 1;
  localparam pos_t FLAP_VELOCITY = -8;
  localparam pos_t MAX_FALL      = 10;

  localparam logic [7:0]  GAMEOVER_HOLD = 8'd120;
  localparam logic [31:0] SCORE_MAX     = 32'd999;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/game_flow_controller_if.sv
// Scene bus between the frame sequencer (slave) and its frame-tick/button source and renderer (master).
// No flow control: outputs are level scene state, iFrameTick is a one-cycle strobe.
interface game_flow_controller_if;
  import game_pkg::*;

  logic    iFrameTick;
  logic    iFlap;
  screen_e oScreen;
  logic    oBGScroll;
  pos_t    oBirdY;
  logic [31:0] oScore;
  pos_t    oPipe1X, oPipe2X, oPipe3X;
  pos_t    oPipe1Y, oPipe2Y, oPipe3Y;

  modport master (
    output iFrameTick, iFlap,
    input  oScreen, oBGScroll, oBirdY, oScore,
    input  oPipe1X, oPipe2X, oPipe3X, oPipe1Y, oPipe2Y, oPipe3Y
  );

  modport slave (
    input  iFrameTick, iFlap,
    output oScreen, oBGScroll, oBirdY, oScore,
    output oPipe1X, oPipe2X, oPipe3X, oPipe1Y, oPipe2Y, oPipe3Y
  );

endinterface

// File: rtl/pipe_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11), free-running every clock; low byte feeds gap heights.
// Latency: new value every cycle; no backpressure.
module pipe_lfsr
  import game_pkg::*;
(
  input  logic       iClock,
  input  logic       iReset,
  output logic [7:0] oValue
);

  logic [15:0] lfsr_q;

  always_ff @(posedge iClock) begin
    if (iReset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  assign oValue = lfsr_q[7:0];

endmodule

// File: rtl/game_flow_controller.sv
// Title/play/game-over sequencer: bird physics, pipe scroll/respawn, score, collision; state moves on iFrameTick only.
// Outputs registered, valid the cycle after a tick; no backpressure. GAME_FLOW_DIFFICULTY_EN scales pipe speed with score.
module game_flow_controller
  import game_pkg::*;
(
  input  logic                   iClock,
  input  logic                   iReset,
  game_flow_controller_if.slave  bus
);

  screen_e     state_q, state_d;
  logic        bg_scroll_q, bg_scroll_d;
  pos_t        bird_y_q, bird_y_d, vel_q, vel_d;
  logic [31:0] score_q, score_d;
  pos_t        pipe_x_q [3], pipe_x_d [3];
  pos_t        pipe_y_q [3], pipe_y_d [3];
  logic        flap_prev_q, flap_pending_q, flap_pending_d;
  logic [7:0]  hold_q, hold_d;
  logic        restart;
  logic [7:0]  lfsr_byte;

  logic        flap_now, hit;
  logic [1:0]  passed;
  pos_t        speed, vel_step, bird_step;
  pos_t        step_x [3], step_y [3];
  logic [31:0] score_step;

  pipe_lfsr u_pipe_lfsr (
    .iClock (iClock),
    .iReset (iReset),
    .oValue (lfsr_byte)
  );

  always_ff @(posedge iClock) begin
    flap_prev_q <= bus.iFlap;
    if (iReset || restart) begin
      state_q        <= SCREEN_TITLE;
      bg_scroll_q    <= 1'b1;
      bird_y_q       <= BIRD_START_Y;
      vel_q          <= '0;
      score_q        <= '0;
      flap_pending_q <= 1'b0;
      hold_q         <= '0;
      for (int i = 0; i < 3; i++) begin
        pipe_x_q[i] <= SCREEN_WIDTH + i * PIPE_SPACING;
        pipe_y_q[i] <= PIPE_RESET_Y;
      end
    end else begin
      state_q        <= state_d;
      bg_scroll_q    <= bg_scroll_d;
      bird_y_q       <= bird_y_d;
      vel_q          <= vel_d;
      score_q        <= score_d;
      flap_pending_q <= flap_pending_d;
      hold_q         <= hold_d;
      for (int i = 0; i < 3; i++) begin
        pipe_x_q[i] <= pipe_x_d[i];
        pipe_y_q[i] <= pipe_y_d[i];
      end
    end
  end

  always_comb begin
    // A rising edge in the tick cycle itself counts for that tick.
    flap_now = flap_pending_q | (bus.iFlap & ~flap_prev_q);

`ifdef GAME_FLOW_DIFFICULTY_EN
    speed = PIPE_SPEED + pos_t'(score_q / 32'd10);
    if (speed > PIPE_SPEED_MAX) speed = PIPE_SPEED_MAX;
`else
    speed = PIPE_SPEED;
`endif

    // One play step; TITLE always holds reset values, so it can start from the registers too.
    vel_step = flap_now ? FLAP_VELOCITY
             : ((vel_q + GRAVITY > MAX_FALL) ? MAX_FALL : vel_q + GRAVITY);
    bird_step = bird_y_q + vel_step;
    if (bird_step < 0) begin
      bird_step = '0;
      vel_step  = '0;
    end

    hit    = (bird_step + BIRD_HEIGHT >= SCREEN_HEIGHT);
    passed = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step_x[i] = pipe_x_q[i] - speed;
      step_y[i] = pipe_y_q[i];
      if (step_x[i] < -PIPE_WIDTH) begin
        step_x[i] = step_x[i] + 3 * PIPE_SPACING;
        step_y[i] = PIPE_Y_MIN + pos_t'({24'd0, lfsr_byte});
      end
      if ((pipe_x_q[i] + PIPE_WIDTH >= BIRD_X) && (step_x[i] + PIPE_WIDTH < BIRD_X))
        passed = passed + 2'd1;
      if ((BIRD_X + BIRD_WIDTH > step_x[i]) && (BIRD_X < step_x[i] + PIPE_WIDTH) &&
          ((bird_step < step_y[i]) || (bird_step + BIRD_HEIGHT > step_y[i] + PIPE_GAP)))
        hit = 1'b1;
    end
    score_step = score_q + {30'd0, passed};
    if (score_step > SCORE_MAX) score_step = SCORE_MAX;

    state_d        = state_q;
    bg_scroll_d    = bg_scroll_q;
    bird_y_d       = bird_y_q;
    vel_d          = vel_q;
    score_d        = score_q;
    hold_d         = hold_q;
    restart        = 1'b0;
    flap_pending_d = bus.iFrameTick ? 1'b0 : flap_now;
    for (int i = 0; i < 3; i++) begin
      pipe_x_d[i] = pipe_x_q[i];
      pipe_y_d[i] = pipe_y_q[i];
    end

    case (state_q)
      SCREEN_TITLE, SCREEN_PLAY: begin
        if (bus.iFrameTick && (state_q == SCREEN_PLAY || flap_now)) begin
          bird_y_d    = bird_step;
          vel_d       = vel_step;
          score_d     = score_step;
          state_d     = hit ? SCREEN_GAME_OVER : SCREEN_PLAY;
          bg_scroll_d = ~hit;
          hold_d      = '0;
          for (int i = 0; i < 3; i++) begin
            pipe_x_d[i] = step_x[i];
            pipe_y_d[i] = step_y[i];
          end
        end
      end
      SCREEN_GAME_OVER: begin
        if (hold_q < GAMEOVER_HOLD) begin
          flap_pending_d = 1'b0;
          if (bus.iFrameTick) hold_d = hold_q + 8'd1;
        end else if (bus.iFrameTick && flap_now) begin
          restart = 1'b1;
        end
      end
      default: state_d = SCREEN_TITLE;
    endcase
  end

  assign bus.oScreen   = state_q;
  assign bus.oBGScroll = bg_scroll_q;
  assign bus.oBirdY    = bird_y_q;
  assign bus.oScore    = score_q;
  assign bus.oPipe1X   = pipe_x_q[0];
  assign bus.oPipe2X   = pipe_x_q[1];
  assign bus.oPipe3X   = pipe_x_q[2];
  assign bus.oPipe1Y   = pipe_y_q[0];
  assign bus.oPipe2Y   = pipe_y_q[1];
  assign bus.oPipe3Y   = pipe_y_q[2];

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: title idle, flap physics, ground death, game-over hold,
// scoring past a pipe, pipe wrap and mid-game reset.
module tb_game_flow_controller;

  logic iClock = 1'b0;
  logic iReset;
  int   total = 0;
  int   bad   = 0;

  game_flow_controller_if bus ();

  game_flow_controller dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One frame strobe, optionally with a flap edge in the same cycle; outputs valid on return.
  task automatic tick(input logic flap);
    @(negedge iClock);
    bus.iFlap      = flap;
    bus.iFrameTick = 1'b1;
    @(negedge iClock);
    bus.iFrameTick = 1'b0;
    bus.iFlap      = 1'b0;
  endtask

  task automatic pulse_flap();
    @(negedge iClock);
    bus.iFlap = 1'b1;
    @(negedge iClock);
    bus.iFlap = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_screen"}, bus.oScreen, 0);
    chk({tag, "_bg"},     bus.oBGScroll, 1);
    chk({tag, "_birdy"},  bus.oBirdY, 228);
    chk({tag, "_score"},  bus.oScore, 0);
    chk({tag, "_p1x"},    bus.oPipe1X, 640);
    chk({tag, "_p2x"},    bus.oPipe2X, 880);
    chk({tag, "_p3x"},    bus.oPipe3X, 1120);
    chk({tag, "_p1y"},    bus.oPipe1Y, 190);
    chk({tag, "_p3y"},    bus.oPipe3Y, 190);
  endtask

  initial begin
    bus.iFrameTick = 1'b0;
    bus.iFlap      = 1'b0;
    iReset         = 1'b1;
    repeat (3) @(negedge iClock);
    iReset = 1'b0;
    chk_reset_values("rst");

    repeat (100) tick(1'b0);
    chk_reset_values("title100");

    // Game 1: single flap, then free fall into the ground.
    tick(1'b1);
    chk("play_screen", bus.oScreen, 1);
    chk("play_y1", bus.oBirdY, 220);
    chk("play_p1x1", bus.oPipe1X, 638);
    tick(1'b0);
    chk("play_y2", bus.oBirdY, 213);
    tick(1'b0);
    chk("play_y3", bus.oBirdY, 207);
    repeat (16) tick(1'b0);
    chk("fall_y19", bus.oBirdY, 247);
    tick(1'b0);
    chk("fall_y20_maxvel", bus.oBirdY, 257);
    repeat (19) tick(1'b0);
    chk("fall_y39", bus.oBirdY, 447);
    chk("fall_screen39", bus.oScreen, 1);
    tick(1'b0);
    chk("ground_screen", bus.oScreen, 2);
    chk("ground_bg", bus.oBGScroll, 0);
    chk("ground_y", bus.oBirdY, 457);
    chk("ground_p1x", bus.oPipe1X, 560);

    // Hold window: flaps on game-over ticks 1..119 are ignored.
    for (int k = 1; k <= 119; k++) begin
      tick(1'b1);
      chk($sformatf("hold_screen_%0d", k), bus.oScreen, 2);
    end
    tick(1'b0);
    chk("hold120_screen", bus.oScreen, 2);
    chk("hold120_y_frozen", bus.oBirdY, 457);
    chk("hold120_p1x_frozen", bus.oPipe1X, 560);
    pulse_flap();
    tick(1'b0);
    chk_reset_values("retitle");

    // Game 2: flap whenever the bird sinks to 240 or below, staying inside the 190..290 gaps.
    tick(1'b1);
    chk("g2_screen", bus.oScreen, 1);
    for (int n = 2; n <= 347; n++) begin
      tick(bus.oBirdY >= 240);
      chk($sformatf("g2_alive_%0d", n), bus.oScreen, 1);
      if (n == 194) begin
        chk("score_pre_p1x", bus.oPipe1X, 252);
        chk("score_pre", bus.oScore, 0);
      end
      if (n == 195) begin
        chk("score_cross_p1x", bus.oPipe1X, 250);
        chk("score_cross", bus.oScore, 1);
      end
      if (n == 200) chk("score_hold", bus.oScore, 1);
      if (n == 314) chk("score_pre_p2", bus.oScore, 1);
      if (n == 315) chk("score_cross_p2", bus.oScore, 2);
      if (n == 346) chk("wrap_pre_p1x", bus.oPipe1X, -52);
    end
    chk("wrap_p1x", bus.oPipe1X, 666);
    chk("wrap_p1y_range", (bus.oPipe1Y >= 60 && bus.oPipe1Y <= 315), 1);
    chk("wrap_p2x", bus.oPipe2X, 186);
    chk("wrap_p3x", bus.oPipe3X, 426);
    chk("wrap_score", bus.oScore, 2);

    // Reset mid-play, coincident with a frame tick.
    @(negedge iClock);
    iReset         = 1'b1;
    bus.iFrameTick = 1'b1;
    @(negedge iClock);
    iReset         = 1'b0;
    bus.iFrameTick = 1'b0;
    chk_reset_values("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Frame-rate game sequencer that drives every scene input of the pixel renderer: screen select, background scroll enable, bird Y, score and three pipe X/Y pairs.
- Runs the title → play → game-over flow, bird physics, pipe scrolling/respawn, scoring and collision.
- All state advances once per frame strobe from the VGA timing block.

Parameters:
- SCREEN_WIDTH, 640, visible width in pixels
- SCREEN_HEIGHT, 480, visible height in pixels
- BIRD_X, 303, fixed bird left edge (320 − 34/2)
- BIRD_WIDTH, 34, bird sprite width
- BIRD_HEIGHT, 24, bird sprite height
- BIRD_START_Y, 228, bird Y on entering TITLE/PLAY
- PIPE_WIDTH, 52, pipe sprite width
- PIPE_GAP, 100, vertical gap height
- PIPE_SPACING, 240, horizontal distance between consecutive pipes
- PIPE_SPEED, 2, pixels per frame pipe scroll
- PIPE_Y_MIN, 60, minimum gap top; gap top = PIPE_Y_MIN + lfsr[7:0]
- GRAVITY, 1, velocity increment per frame
- FLAP_VELOCITY, −8, velocity loaded on flap
- MAX_FALL, 10, velocity clamp
- GAMEOVER_HOLD, 120, frames flaps are ignored after death

Ports:
- iClock  in  1  system clock
- iReset  in  1  synchronous, active-high reset
- iFrameTick  in  1  one-cycle strobe per frame
- iFlap  in  1  synchronised flap button, level
- oScreen  out  2  0 = TITLE, 1 = PLAY, 2 = GAME_OVER
- oBGScroll  out  1  background scroll enable
- oBirdY  out  32 signed  bird top edge
- oScore  out  32  score, 0..999
- oPipe1X/oPipe2X/oPipe3X  out  32 signed  pipe left edges
- oPipe1Y/oPipe2Y/oPipe3Y  out  32 signed  gap top edges

Behaviour:
- Reset values:
  - state TITLE, oScreen = 0, oBGScroll = 1
  - oBirdY = 228, velocity 0, oScore = 0
  - pipe X = 640 / 880 / 1120, all pipe Y = 190
  - flap-pending = 0, hold counter = 0
- Flap capture: a rising edge of iFlap (registered previous level) sets flap-pending. It is consumed on the next iFrameTick. An edge in the same cycle as the tick counts for that tick.
- All state updates happen only on iFrameTick cycles. Outputs are registered and show the new values one cycle after the tick.
- TITLE:
  - oBGScroll = 1, nothing else moves.
  - Tick with pending flap → PLAY. Same tick: bird/pipes/score take reset values, then one PLAY step runs with the flap applied, so oBirdY = 220.
- PLAY, per tick, in this order:
  1. vel = pending ? FLAP_VELOCITY : min(vel + GRAVITY, MAX_FALL).
  2. birdY += vel. If the result is < 0, birdY = 0 and vel = 0.
  3. Each pipe: X −= speed. If new X < −PIPE_WIDTH: X += 3·PIPE_SPACING, Y = PIPE_Y_MIN + lfsr[7:0].
  4. Score: +1 per pipe where oldX + PIPE_WIDTH ≥ BIRD_X and newX + PIPE_WIDTH < BIRD_X. Saturates at 999.
  5. Collision, evaluated on post-update values:
     - ground: birdY + BIRD_HEIGHT ≥ SCREEN_HEIGHT
     - pipe: BIRD_X + BIRD_WIDTH > X, BIRD_X < X + PIPE_WIDTH, and (birdY < Y or birdY + BIRD_HEIGHT > Y + PIPE_GAP)
  6. On collision → GAME_OVER, oBGScroll = 0, hold counter = 0.
- Same-tick score and collision: the score increments first, then the state goes to GAME_OVER.
- GAME_OVER:
  - All positions and the score are frozen.
  - The hold counter increments per tick up to GAMEOVER_HOLD.
  - While hold < GAMEOVER_HOLD, pending flaps are cleared.
  - Afterwards, a tick with pending flap → TITLE with reset values (oBGScroll = 1).
- Reset mid-frame or mid-game: the next cycle shows full reset values regardless of iFrameTick.
- Arithmetic: all position math is 32-bit signed, score is unsigned. oScreen encoding is never 3.

Optional Feature:
- Macro GAME_FLOW_DIFFICULTY_EN.
- Defined: speed = min(PIPE_SPEED + oScore/10, 4), recomputed each tick from the pre-increment score.
- Undefined: speed = PIPE_SPEED constant.

Decomposition:
- Shared package game_pkg holds:
  - screen encodings SCREEN_TITLE/SCREEN_PLAY/SCREEN_GAME_OVER
  - geometry constants (screen, bird, pipe, gap), shared with the renderer
- Sub-module pipe_lfsr:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11, seed 0xACE1, reset by iReset
  - steps every clock, so gap heights depend on player timing

Test Plan:
- Reset, 100 ticks, no flap → oScreen = 0, oBGScroll = 1, oBirdY = 228, oPipe1X = 640, oScore = 0.
- Flap edge in TITLE then tick → oScreen = 1, oBirdY = 220. Next tick oBirdY = 213, then 207.
- PLAY with no further flaps → velocity climbs to 10 and holds. On the tick where oBirdY + 24 ≥ 480 → oScreen = 2, oBGScroll = 0, oBirdY frozen.
- Bench flaps to keep the bird in pipe1's gap → oScore goes 0→1 exactly on the tick oPipe1X moves 252→250, with no further increment from that pipe.
- Pipe wrap: oPipe1X goes −52 → 666 on the next tick (−54 + 720), and oPipe1Y = 60 + lfsr[7:0] lies in 60..315.
- Game over: flaps on ticks 1..119 → stays 2. Flap after tick 120 → oScreen = 0 with all reset values. iReset mid-PLAY → reset values next cycle.
